// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, branch flush priority,
// EX operand forwarding selects and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic [4:0]       EX_Rs,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_WriteReg,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic             MEM_PCSrc,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01
  } state_t;

  // Remaining-cycle load value: the first stall cycle happens in RUN and the
  // last one happens with remaining==0, hence the minus two.
  localparam int         LOAD_INT   = (STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0;
  localparam logic [2:0] STALL_LOAD = LOAD_INT[2:0];
  localparam bit         MULTI      = (STALL_CYCLES > 1);

  state_t     state, state_next;
  logic [2:0] remaining, remaining_next;
  logic       hazard, stall_now;

  // EX_RegWrite is part of the destination bundle but a load always writes,
  // so only MemRead qualifies the load-use check.
  logic       unused_ex_regwrite;
  assign unused_ex_regwrite = EX_RegWrite;

  // Load-use detection and the stall request (STALL holds regardless of EX).
  always_comb begin
    hazard = EX_MemRead && (EX_WriteReg != 5'd0) &&
             ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    stall_now = ((state == RUN) && hazard && !MEM_PCSrc) ||
                ((state == STALL) && !MEM_PCSrc);
  end

  // Next-state logic; a taken branch/jump always wins and returns to RUN.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    if (MEM_PCSrc) begin
      state_next     = RUN;
      remaining_next = 3'd0;
    end else if (state == RUN) begin
      if (hazard && MULTI) begin
        state_next     = STALL;
        remaining_next = STALL_LOAD;
      end
    end else begin
      if (remaining != 3'd0) begin
        remaining_next = remaining - 3'd1;
      end else begin
        state_next = RUN;
      end
    end
  end

  // Pipeline enables and flushes; reset forces the idle pattern.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    if (!Reset) begin
      if (MEM_PCSrc) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
      end else if (stall_now) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  // Forwarding selects; the younger MEM result beats the WB result.
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (!Reset) begin
      if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == EX_Rs)) begin
        ForwardA = 2'b10;
      end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == EX_Rs)) begin
        ForwardA = 2'b01;
      end
      if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == EX_Rt)) begin
        ForwardB = 2'b10;
      end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == EX_Rt)) begin
        ForwardB = 2'b01;
      end
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= RUN;
      remaining  <= 3'd0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (stall_now && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (MEM_PCSrc && (FlushCount != {CNT_W{1'b1}})) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

  assign State = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances sharing inputs
// (one-cycle stall, three-cycle stall, 4-bit counters).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WriteReg, MEM_WriteReg, WB_WriteReg;
  logic       ID_UsesRt, EX_MemRead, EX_RegWrite, MEM_RegWrite, WB_RegWrite, MEM_PCSrc;

  logic        a_pc, a_ifid, a_fif, a_fex, a_fmem;
  logic [1:0]  a_fa, a_fb, a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifid, b_fif, b_fex, b_fmem;
  logic [1:0]  b_fa, b_fb, b_st;
  logic [15:0] b_sc, b_fc;
  logic        c_pc, c_ifid, c_fif, c_fex, c_fmem;
  logic [1:0]  c_fa, c_fb, c_st;
  logic [3:0]  c_sc, c_fc;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11111;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg), .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .MEM_PCSrc(MEM_PCSrc),
    .PCWrite(a_pc), .IF_ID_Write(a_ifid), .IF_ID_Flush(a_fif), .ID_EX_Flush(a_fex),
    .EX_MEM_Flush(a_fmem), .ForwardA(a_fa), .ForwardB(a_fb), .State(a_st),
    .StallCount(a_sc), .FlushCount(a_fc));

  pipeline_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg), .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .MEM_PCSrc(MEM_PCSrc),
    .PCWrite(b_pc), .IF_ID_Write(b_ifid), .IF_ID_Flush(b_fif), .ID_EX_Flush(b_fex),
    .EX_MEM_Flush(b_fmem), .ForwardA(b_fa), .ForwardB(b_fb), .State(b_st),
    .StallCount(b_sc), .FlushCount(b_fc));

  pipeline_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) dut4 (
    .clk(clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg), .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .MEM_PCSrc(MEM_PCSrc),
    .PCWrite(c_pc), .IF_ID_Write(c_ifid), .IF_ID_Flush(c_fif), .ID_EX_Flush(c_fex),
    .EX_MEM_Flush(c_fmem), .ForwardA(c_fa), .ForwardB(c_fb), .State(c_st),
    .StallCount(c_sc), .FlushCount(c_fc));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns every input to a quiet, hazard-free value.
  task automatic applyStimulus();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
    EX_Rs = 5'd0; EX_Rt = 5'd0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    MEM_RegWrite = 1'b0; MEM_WriteReg = 5'd0; WB_RegWrite = 1'b0; WB_WriteReg = 5'd0;
    MEM_PCSrc = 1'b0;
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks follow 2 ns later.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    applyStimulus();
    stepClock();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus();
    // Hazard and forwarding matches present while in reset: outputs stay idle.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd8; EX_Rs = 5'd8; EX_Rt = 5'd8;
    stepClock();
    settle();
    checkOutput("rst_all1", {a_pc, a_ifid, a_fif, a_fex, a_fmem, a_fa, a_fb, a_st}, {IDLE, 6'd0});
    checkOutput("rst_all3", {b_pc, b_ifid, b_fif, b_fex, b_fmem, b_fa, b_fb, b_st}, {IDLE, 6'd0});
    checkOutput("rst_all4", {c_pc, c_ifid, c_fif, c_fex, c_fmem, c_fa, c_fb, c_st}, {IDLE, 6'd0});
    checkOutput("rst_cnt1", {a_sc, a_fc}, 32'd0);
    checkOutput("rst_cnt3", {b_sc, b_fc}, 32'd0);
    checkOutput("rst_cnt4", {c_sc, c_fc}, 32'd0);

    // One-cycle load-use hazard, then the load leaves EX.
    Reset = 1'b0;
    applyStimulus();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    settle();
    checkOutput("lu_ctl1", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, STALL);
    checkOutput("lu_ctl3", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, STALL);
    stepClock();
    EX_MemRead = 1'b0;
    settle();
    checkOutput("lu1_state", a_st, 2'b00);
    checkOutput("lu1_scnt", a_sc, 16'd1);
    checkOutput("lu1_ctl_after", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, IDLE);
    checkOutput("lu4_scnt", c_sc, 4'd1);
    checkOutput("lu3_c2_state", b_st, 2'b01);
    checkOutput("lu3_c2_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, STALL);
    checkOutput("lu3_c2_scnt", b_sc, 16'd1);
    stepClock();
    settle();
    checkOutput("lu3_c3_state", b_st, 2'b01);
    checkOutput("lu3_c3_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, STALL);
    checkOutput("lu3_c3_scnt", b_sc, 16'd2);
    checkOutput("lu1_scnt_hold", a_sc, 16'd1);
    stepClock();
    settle();
    checkOutput("lu3_end_state", b_st, 2'b00);
    checkOutput("lu3_end_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, IDLE);
    checkOutput("lu3_end_scnt", b_sc, 16'd3);

    // Rt only counts when the instruction reads it; register 0 never hazards.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd7; ID_Rs = 5'd1; ID_Rt = 5'd7; ID_UsesRt = 1'b0;
    settle();
    checkOutput("rt_unused", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, IDLE);
    ID_UsesRt = 1'b1;
    #1;
    checkOutput("rt_used", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, STALL);
    EX_WriteReg = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    #1;
    checkOutput("r0_nohaz", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, IDLE);
    EX_MemRead = 1'b0; EX_RegWrite = 1'b1; EX_WriteReg = 5'd7; ID_Rt = 5'd7;
    #1;
    checkOutput("noload_nohaz", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, IDLE);

    // Reset during the second stall cycle of the three-cycle instance.
    doReset();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    stepClock();
    applyStimulus();
    settle();
    checkOutput("rs_mid_state", b_st, 2'b01);
    Reset = 1'b1;
    #1;
    checkOutput("rs_in_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, IDLE);
    stepClock();
    Reset = 1'b0;
    settle();
    checkOutput("rs_after_state", b_st, 2'b00);
    checkOutput("rs_after_cnt", {b_sc, b_fc}, 32'd0);
    checkOutput("rs_after_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, IDLE);

    // Hazard and taken branch together: branch flush wins.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5; MEM_PCSrc = 1'b1;
    settle();
    checkOutput("br_ctl1", {a_pc, a_ifid, a_fif, a_fex, a_fmem}, FLUSH);
    checkOutput("br_ctl3", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, FLUSH);
    stepClock();
    applyStimulus();
    settle();
    checkOutput("br_state3", b_st, 2'b00);
    checkOutput("br_fcnt3", b_fc, 16'd1);
    checkOutput("br_scnt3", b_sc, 16'd0);
    checkOutput("br_scnt1", a_sc, 16'd0);

    // Taken branch arriving while already in STALL.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    stepClock();
    applyStimulus();
    MEM_PCSrc = 1'b1;
    settle();
    checkOutput("brst_state", b_st, 2'b01);
    checkOutput("brst_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, FLUSH);
    stepClock();
    MEM_PCSrc = 1'b0;
    settle();
    checkOutput("brst_after_state", b_st, 2'b00);
    checkOutput("brst_after_ctl", {b_pc, b_ifid, b_fif, b_fex, b_fmem}, IDLE);
    checkOutput("brst_scnt", b_sc, 16'd1);
    checkOutput("brst_fcnt", b_fc, 16'd2);

    // Forwarding selects.
    MEM_RegWrite = 1'b1; WB_RegWrite = 1'b1; MEM_WriteReg = 5'd8; WB_WriteReg = 5'd8;
    EX_Rs = 5'd8; EX_Rt = 5'd3;
    settle();
    checkOutput("fwdA_mem", a_fa, 2'b10);
    checkOutput("fwdB_none", a_fb, 2'b00);
    MEM_RegWrite = 1'b0;
    #1;
    checkOutput("fwdA_wb", a_fa, 2'b01);
    MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd0; WB_WriteReg = 5'd0; EX_Rs = 5'd0; EX_Rt = 5'd0;
    #1;
    checkOutput("fwdA_r0", a_fa, 2'b00);
    checkOutput("fwdB_r0", a_fb, 2'b00);
    MEM_WriteReg = 5'd9; WB_WriteReg = 5'd9; EX_Rt = 5'd9; EX_Rs = 5'd4;
    #1;
    checkOutput("fwdB_mem", a_fb, 2'b10);
    checkOutput("fwdA_miss", a_fa, 2'b00);
    MEM_WriteReg = 5'd4;
    #1;
    checkOutput("fwdB_wb", a_fb, 2'b01);
    checkOutput("fwdA_mem2", b_fa, 2'b10);

    // Seventeen flush cycles saturate the 4-bit counter.
    doReset();
    MEM_PCSrc = 1'b1;
    for (int i = 0; i < 15; i++) stepClock();
    settle();
    checkOutput("sat_fc4_15", c_fc, 4'd15);
    stepClock();
    stepClock();
    MEM_PCSrc = 1'b0;
    settle();
    checkOutput("sat_fc4_17", c_fc, 4'd15);
    checkOutput("sat_fc1_17", a_fc, 16'd17);
    checkOutput("sat_sc4", c_sc, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_CYCLES, default 1, range 1..7: number of cycles a load-use hazard freezes IF and ID.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port ID_UsesRt  input  1  ID instruction reads Rt.
REQ-007 SHALL have ports EX_Rs, EX_Rt  input  5 each  source registers of the instruction in EX.
REQ-008 SHALL have ports EX_MemRead, EX_RegWrite  input  1 each, and EX_WriteReg  input  5  ID/EX destination info.
REQ-009 SHALL have ports MEM_RegWrite  input  1 and MEM_WriteReg  input  5  EX/MEM destination info.
REQ-010 SHALL have ports WB_RegWrite  input  1 and WB_WriteReg  input  5  MEM/WB destination info.
REQ-011 SHALL have port MEM_PCSrc  input  1  branch or jump taken, resolved in MEM.
REQ-012 SHALL have ports PCWrite, IF_ID_Write  output  1 each  PC and IF/ID enables.
REQ-013 SHALL have ports IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  output  1 each  bubble insertion.
REQ-014 SHALL have ports ForwardA, ForwardB  output  2 each  EX operand-mux select.
REQ-015 SHALL have port State  output  2  FSM state: 00 RUN, 01 STALL.
REQ-016 SHALL have ports StallCount, FlushCount  output  CNT_W each  performance counters.

Function
REQ-017 SHALL define hazard = EX_MemRead & (EX_WriteReg!=0) & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
REQ-018 SHALL define stall_now = (State==RUN & hazard & !MEM_PCSrc) | (State==STALL & !MEM_PCSrc).
REQ-019 SHALL drive stall outputs combinationally when stall_now: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
REQ-020 SHALL drive flush outputs combinationally when MEM_PCSrc: IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PCWrite=1, IF_ID_Write=1.
REQ-021 SHALL otherwise drive PCWrite=1, IF_ID_Write=1, all flushes 0.
REQ-022 SHALL transition RUN->STALL only when hazard & !MEM_PCSrc & STALL_CYCLES>1, loading 3-bit remaining counter with STALL_CYCLES-2.
REQ-023 SHALL stay in STALL while remaining!=0, decrementing each cycle; when remaining==0 in STALL, next state RUN.
REQ-024 SHALL ignore hazard while in STALL (stall held independent of EX inputs).
REQ-025 SHALL give MEM_PCSrc priority over any stall, in any state: flush this cycle, next state RUN, remaining cleared.
REQ-026 SHALL set ForwardA=10 when MEM_RegWrite & MEM_WriteReg!=0 & MEM_WriteReg==EX_Rs; else 01 when WB_RegWrite & WB_WriteReg!=0 & WB_WriteReg==EX_Rs; else 00.
REQ-027 SHALL compute ForwardB identically against EX_Rt; MEM match beats WB match.
REQ-028 SHALL increment StallCount by 1 on each clock where stall_now=1, saturating at all-ones.
REQ-029 SHALL increment FlushCount by 1 on each clock where MEM_PCSrc=1, saturating at all-ones.

Reset
REQ-030 SHALL, on posedge clk with Reset=1, force State=RUN, remaining=0, StallCount=0, FlushCount=0, overriding all other inputs, including mid-STALL.
REQ-031 SHALL, while Reset=1, drive PCWrite=1, IF_ID_Write=1, all flushes 0, ForwardA=ForwardB=00.

Verification
REQ-032 SHALL cover: STALL_CYCLES=1, EX_MemRead=1, EX_WriteReg=5, ID_Rs=5 for one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle, State stays RUN, StallCount=1.
REQ-033 SHALL cover: STALL_CYCLES=3, same hazard one cycle then EX_MemRead=0 -> stall held 3 consecutive cycles, State=01 for cycles 2-3, then RUN, StallCount=3.
REQ-034 SHALL cover: hazard and MEM_PCSrc=1 same cycle -> all three flushes 1, PCWrite=1, no stall, FlushCount=1, StallCount=0.
REQ-035 SHALL cover: MEM_WriteReg=WB_WriteReg=EX_Rs=8, both RegWrite=1 -> ForwardA=10; MEM_RegWrite=0 -> 01; EX_Rs=0 with writes to 0 -> 00.
REQ-036 SHALL cover: Reset=1 during second STALL cycle (STALL_CYCLES=3) -> next cycle State=RUN, counters 0, PCWrite=1.
REQ-037 SHALL cover: CNT_W=4, 17 flush cycles -> FlushCount saturates at 15.
